axis_pkt_fifo: RTL and testbench

//  Store-and-forward AXI4-Stream packet buffer placed downstream of the stream processing stage, ahead of the DMA S2MM port.
//  A packet is forwarded only after its tlast word has been written in full.

---
 rtl/axis_pkt_pkg.sv | 32 +++
 rtl/axis_pkt_ram.sv | 51 +++++
 rtl/axis_pkt_fifo.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_pkg
//   Shared definitions for the AXI4-Stream store-and-forward packet FIFO.
//   - wr_state_e : write-side FSM states (WR_ACCEPT = 1'b0, WR_DROP = 1'b1)
//   - Stored-word layout helpers. Each buffered word is {tlast, tkeep, tdata}:
//       tdata at [TDATA_LSB +: DATA_W]
//       tkeep at [tkeep_lsb(DATA_W) +: KEEP_W]
//       tlast at [tlast_bit(DATA_W, KEEP_W)]
//     word_w(DATA_W, KEEP_W) gives the total stored width.
// -----------------------------------------------------------------------------
package axis_pkt_pkg;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_e;

    localparam int TDATA_LSB = 0;

    function automatic int tkeep_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int tlast_bit(input int data_w, input int keep_w);
        return data_w + keep_w;
    endfunction

    function automatic int word_w(input int data_w, input int keep_w);
        return data_w + keep_w + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_ram.sv
// -----------------------------------------------------------------------------
// axis_pkt_ram
//   Simple dual-port RAM backing the packet FIFO: one write port and one
//   synchronous read port (read data valid one clock after re).
//   Contents are not reset; the FIFO pointers decide what is meaningful.
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module axis_pkt_ram
    import axis_pkt_pkg::*;
#(
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Synchronous read port; rdata holds its value when re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_pkt_fifo
//   Store-and-forward AXI4-Stream packet buffer. A packet becomes visible on
//   the master side only after its tlast beat has been written. Packets that
//   do not fit are discarded whole (drop_pulse marks the dropped tlast), so
//   the consumer never sees a truncated packet. The slave side is never
//   back-pressured.
//
//   Optional feature macro: AXIS_PKT_STATS_EN adds pkt_in_cnt / pkt_drop_cnt.
//
// Ports
//   clk            in   clock
//   reset          in   synchronous, active-low reset
//   s_axis_*       in   input stream (tdata, tkeep, tlast, tvalid); tready out
//   m_axis_*       out  output stream (tdata, tkeep, tlast, tvalid); tready in
//   pkt_in_cnt     out  [AXIS_PKT_STATS_EN] committed packets, wraps at 16 bits
//   pkt_drop_cnt   out  [AXIS_PKT_STATS_EN] dropped packets, wraps at 16 bits
//   pkt_count      out  committed packets not yet fully sent
//   drop_pulse     out  one-cycle pulse when a dropped packet's tlast is taken
// -----------------------------------------------------------------------------
module axis_pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
`ifdef AXIS_PKT_STATS_EN
    output logic [15:0]       pkt_in_cnt,
    output logic [15:0]       pkt_drop_cnt,
`endif
    output logic [ADDR_W:0]   pkt_count,
    output logic              drop_pulse
);

    localparam int WORD_W   = word_w(DATA_W, KEEP_W);
    localparam int KEEP_LSB = tkeep_lsb(DATA_W);
    localparam int LAST_BIT = tlast_bit(DATA_W, KEEP_W);
    localparam int PTR_W    = ADDR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    // ---------------------------------------------------------------- write side
    wr_state_e        wr_state_q, wr_state_d;
    logic [PTR_W-1:0] wr_cur_q, wr_cur_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             s_tready_q;
    logic             drop_pulse_q, drop_pulse_d;
    logic             s_beat_s;
    logic             full_s;
    logic             ram_we_s;
    logic             commit_s;
    logic [WORD_W-1:0] s_word_s;

    // ----------------------------------------------------------------- read side
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              rd_pend_q;
    logic [1:0]        occ_q, occ_d;
    logic [1:0]        occ_after_pop_s;
    logic [WORD_W-1:0] buf0_q, buf0_d;
    logic [WORD_W-1:0] buf1_q, buf1_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic [PTR_W-1:0]  pkt_count_q, pkt_count_d;
    logic              avail_s;
    logic              pop_s;
    logic              rd_issue_s;
    logic              dec_s;
    logic [WORD_W-1:0] ram_rdata_s;

    assign s_beat_s = s_axis_tvalid & s_tready_q;
    assign s_word_s = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    // rd_ptr advances when a read is issued, so prefetched words no longer
    // occupy RAM space.
    assign full_s   = (wr_cur_q - rd_ptr_q) == DEPTH_CNT;
    assign avail_s  = rd_ptr_q != wr_ptr_q;

    // Write FSM: speculative write at wr_cur, commit on tlast, rewind on overflow.
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_cur_d     = wr_cur_q;
        wr_ptr_d     = wr_ptr_q;
        drop_pulse_d = 1'b0;
        ram_we_s     = 1'b0;
        commit_s     = 1'b0;
        case (wr_state_q)
            WR_ACCEPT: begin
                if (s_beat_s && !full_s) begin
                    ram_we_s = 1'b1;
                    wr_cur_d = wr_cur_q + PTR_ONE;
                    if (s_axis_tlast) begin
                        wr_ptr_d = wr_cur_q + PTR_ONE;
                        commit_s = 1'b1;
                    end else begin
                        commit_s = 1'b0;
                    end
                end else if (s_beat_s) begin
                    // Overflow: throw away everything written for this packet.
                    wr_cur_d = wr_ptr_q;
                    if (s_axis_tlast) begin
                        drop_pulse_d = 1'b1;
                    end else begin
                        wr_state_d = WR_DROP;
                    end
                end else begin
                    wr_state_d = WR_ACCEPT;
                end
            end
            WR_DROP: begin
                if (s_beat_s && s_axis_tlast) begin
                    drop_pulse_d = 1'b1;
                    wr_state_d   = WR_ACCEPT;
                end else begin
                    wr_state_d = WR_DROP;
                end
            end
            default: begin
                wr_state_d = WR_ACCEPT;
            end
        endcase
    end

    // Write-side state, pointers, input ready and drop pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_state_q   <= WR_ACCEPT;
            wr_cur_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            s_tready_q   <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_cur_q     <= wr_cur_d;
            wr_ptr_q     <= wr_ptr_d;
            s_tready_q   <= 1'b1;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    axis_pkt_ram #(
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_cur_q[ADDR_W-1:0]),
        .wdata (s_word_s),
        .re    (rd_issue_s),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    // Occupancy is taken after this cycle's pop so a steady stream can issue
    // one read per cycle while keeping at most two words buffered or in flight.
    assign pop_s           = m_tvalid_q & m_axis_tready;
    assign occ_after_pop_s = pop_s ? (occ_q - 2'd1) : occ_q;
    assign rd_issue_s      = avail_s &&
                             (({1'b0, occ_after_pop_s} + {2'b00, rd_pend_q}) < 3'd2);
    assign dec_s           = pop_s & buf0_q[LAST_BIT];

    // Two-entry output buffer: buf0 is the head driving m_axis, buf1 queues.
    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        occ_d    = occ_after_pop_s;
        rd_ptr_d = rd_ptr_q;
        if (pop_s) begin
            buf0_d = buf1_q;
        end else begin
            buf0_d = buf0_q;
        end
        if (rd_pend_q) begin
            if (occ_after_pop_s == 2'd0) begin
                buf0_d = ram_rdata_s;
            end else begin
                buf1_d = ram_rdata_s;
            end
            occ_d = occ_after_pop_s + 2'd1;
        end else begin
            occ_d = occ_after_pop_s;
        end
        if (rd_issue_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        m_tvalid_d = (occ_d != 2'd0);
    end

    // Committed-packet counter; a simultaneous commit and send cancel out.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (commit_s && !dec_s) begin
            pkt_count_d = pkt_count_q + PTR_ONE;
        end else if (!commit_s && dec_s) begin
            pkt_count_d = pkt_count_q - PTR_ONE;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Read-side pointers, output buffer and packet counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= {PTR_W{1'b0}};
            rd_pend_q   <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= {WORD_W{1'b0}};
            buf1_q      <= {WORD_W{1'b0}};
            m_tvalid_q  <= 1'b0;
            pkt_count_q <= {PTR_W{1'b0}};
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            rd_pend_q   <= rd_issue_s;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            m_tvalid_q  <= m_tvalid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = buf0_q[TDATA_LSB +: DATA_W];
    assign m_axis_tkeep  = buf0_q[KEEP_LSB +: KEEP_W];
    assign m_axis_tlast  = buf0_q[LAST_BIT];
    assign m_axis_tvalid = m_tvalid_q;
    assign pkt_count     = pkt_count_q;
    assign drop_pulse    = drop_pulse_q;

`ifdef AXIS_PKT_STATS_EN
    logic [15:0] pkt_in_cnt_q, pkt_in_cnt_d;
    logic [15:0] pkt_drop_cnt_q, pkt_drop_cnt_d;

    // Statistics counters; they wrap naturally at 16 bits.
    always_comb begin
        pkt_in_cnt_d   = pkt_in_cnt_q;
        pkt_drop_cnt_d = pkt_drop_cnt_q;
        if (commit_s) begin
            pkt_in_cnt_d = pkt_in_cnt_q + 16'd1;
        end else begin
            pkt_in_cnt_d = pkt_in_cnt_q;
        end
        if (drop_pulse_d) begin
            pkt_drop_cnt_d = pkt_drop_cnt_q + 16'd1;
        end else begin
            pkt_drop_cnt_d = pkt_drop_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_in_cnt_q   <= 16'd0;
            pkt_drop_cnt_q <= 16'd0;
        end else begin
            pkt_in_cnt_q   <= pkt_in_cnt_d;
            pkt_drop_cnt_q <= pkt_drop_cnt_d;
        end
    end

    assign pkt_in_cnt   = pkt_in_cnt_q;
    assign pkt_drop_cnt = pkt_drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_fifo
//   Self-checking bench for axis_pkt_fifo with ADDR_W=4 (16-word buffer).
//   Inputs are driven and outputs sampled on the falling clock edge; a beat
//   is counted as transferred when valid and ready are both high there.
//   Expected output is kept as a queue of whole committed packets.
// -----------------------------------------------------------------------------
module tb_axis_pkt_fifo;

    localparam int DATA_W = 32;
    localparam int KEEP_W = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic [KEEP_W-1:0] s_axis_tkeep = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [ADDR_W:0]   pkt_count;
    logic              drop_pulse;
`ifdef AXIS_PKT_STATS_EN
    logic [15:0]       pkt_in_cnt;
    logic [15:0]       pkt_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_pkt_fifo #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef AXIS_PKT_STATS_EN
        .pkt_in_cnt    (pkt_in_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
`endif
        .pkt_count     (pkt_count),
        .drop_pulse    (drop_pulse)
    );

    function automatic beat_t out_beat();
        beat_t b;
        b.last = m_axis_tlast;
        b.keep = m_axis_tkeep;
        b.data = m_axis_tdata;
        return b;
    endfunction

    task automatic drive_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drive_beat(input beat_t b);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
    endtask

    // Leaves the bench at a falling edge where s_axis_tready is already 1.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        @(negedge clk);
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== 37'd0) begin errors++; $display("FAIL reset_outdata: got %h/%h/%b want 0", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", s_axis_tready); end
    endtask

    // One 4-word packet; check store-and-forward latency and back-to-back output.
    task automatic test_single_packet();
        beat_t b;
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: beat %0d got %b want 0", i, m_axis_tvalid); end
            b.data = 32'(8'h11 * (i + 1));
            b.keep = 4'hF;
            b.last = (i == 3);
            drive_beat(b);
            @(negedge clk);
        end
        drive_idle();
        checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL t1_pkt_count_commit: got %0d want 1", pkt_count); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_edge1: got %b want 0", m_axis_tvalid); end
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_edge2: got %b want 0", m_axis_tvalid); end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            b.data = 32'(8'h11 * (j + 1));
            b.keep = 4'hF;
            b.last = (j == 3);
            checks++; if (m_axis_tvalid !== 1'b1 || out_beat() !== b) begin errors++; $display("FAIL t1_word%0d: got v=%b %h want v=1 %h", j, m_axis_tvalid, out_beat(), b); end
            @(negedge clk);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_after: got %b want 0", m_axis_tvalid); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL t1_pkt_count_sent: got %0d want 0", pkt_count); end
    endtask

    // Four 5-word packets into a blocked output; the fourth cannot fit.
    task automatic test_overflow();
        beat_t b;
        beat_t exp[$];
        int drops = 0;
        int drop_at = -1;
        int got = 0;
        int lasts = 0;
        do_reset();
        m_axis_tready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 5; i++) begin
                b.data = 32'(p * 16 + i);
                b.keep = 4'(i + 1);
                b.last = (i == 4);
                drive_beat(b);
                if (p < 3) exp.push_back(b);
                @(negedge clk);
                if (drop_pulse === 1'b1) begin
                    drops++;
                    drop_at = p * 5 + i;
                end
            end
        end
        drive_idle();
        @(negedge clk);
        if (drop_pulse === 1'b1) drops++;
        checks++; if (drops !== 1 || drop_at !== 19) begin errors++; $display("FAIL t2_drop: got %0d pulses at beat %0d want 1 at beat 19", drops, drop_at); end
        checks++; if (pkt_count !== 5'd3) begin errors++; $display("FAIL t2_pkt_count: got %0d want 3", pkt_count); end
`ifdef AXIS_PKT_STATS_EN
        checks++; if (pkt_in_cnt !== 16'd3) begin errors++; $display("FAIL t6_pkt_in_cnt: got %0d want 3", pkt_in_cnt); end
        checks++; if (pkt_drop_cnt !== 16'd1) begin errors++; $display("FAIL t6_pkt_drop_cnt: got %0d want 1", pkt_drop_cnt); end
`endif
        m_axis_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (m_axis_tvalid === 1'b1) begin
                got++;
                if (m_axis_tlast === 1'b1) lasts++;
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL t2_extra_word: got %h want nothing", out_beat());
                end else begin
                    b = exp.pop_front();
                    if (out_beat() !== b) begin errors++; $display("FAIL t2_word: got %h want %h", out_beat(), b); end
                end
            end
            @(negedge clk);
        end
        checks++; if (got !== 15 || lasts !== 3) begin errors++; $display("FAIL t2_drain: got %0d words %0d tlasts want 15 words 3 tlasts", got, lasts); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL t2_pkt_count_end: got %0d want 0", pkt_count); end
    endtask

    // A 20-word packet can never fit; the following 3-word packet must.
    task automatic test_oversize();
        beat_t b;
        beat_t got[$];
        int drops = 0;
        do_reset();
        m_axis_tready = 1'b1;
        for (int c = 0; c < 43; c++) begin
            if (m_axis_tvalid === 1'b1) got.push_back(out_beat());
            if (drop_pulse === 1'b1) drops++;
            if (c < 20) begin
                b.data = 32'(256 + c); b.keep = 4'hF; b.last = (c == 19);
                drive_beat(b);
            end else if (c < 23) begin
                b.data = 32'(10 + c - 20); b.keep = 4'hF; b.last = (c == 22);
                drive_beat(b);
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
        checks++; if (drops !== 1) begin errors++; $display("FAIL t3_drops: got %0d want 1", drops); end
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL t3_count: got %0d words want 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                b.data = 32'(10 + k); b.keep = 4'hF; b.last = (k == 2);
                if (got[k] !== b) begin errors++; $display("FAIL t3_word%0d: got %h want %h", k, got[k], b); end
            end
        end
    endtask

    // Sub-word tkeep preserved; output held steady while tready toggles.
    task automatic test_keep_toggle();
        beat_t b;
        beat_t held;
        beat_t exp[$];
        bit hold = 1'b0;
        int got = 0;
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b.data = $urandom;
            b.keep = (i == 5) ? 4'h3 : 4'hF;
            b.last = (i == 5);
            exp.push_back(b);
            drive_beat(b);
            @(negedge clk);
        end
        drive_idle();
        for (int c = 0; c < 40 && got < 6; c++) begin
            m_axis_tready = (c % 2 == 0);
            if (m_axis_tvalid === 1'b1) begin
                if (hold) begin
                    checks++; if (out_beat() !== held) begin errors++; $display("FAIL t4_hold: got %h want %h", out_beat(), held); end
                end
                if (m_axis_tready) begin
                    got++;
                    b = exp.pop_front();
                    checks++; if (out_beat() !== b) begin errors++; $display("FAIL t4_word%0d: got %h want %h", got - 1, out_beat(), b); end
                    hold = 1'b0;
                end else begin
                    held = out_beat();
                    hold = 1'b1;
                end
            end else begin
                hold = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (got !== 6) begin errors++; $display("FAIL t4_count: got %0d words want 6", got); end
    endtask

    // Reset in the middle of both input and output activity.
    task automatic test_reset_mid();
        beat_t b;
        beat_t got[$];
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b.data = 32'(32'h5000 + i); b.keep = 4'hF; b.last = (i == 3);
            drive_beat(b);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        b.data = 32'h6000; b.keep = 4'hF; b.last = 1'b0;
        drive_beat(b);
        @(negedge clk);
        b.data = 32'h6001;
        drive_beat(b);
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t5_mid_transfer: got %b want 1", m_axis_tvalid); end
        reset = 1'b0;
        b.data = 32'h6002;
        drive_beat(b);
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b want 0", m_axis_tvalid); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL t5_pkt_count: got %0d want 0", pkt_count); end
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        for (int c = 0; c < 22; c++) begin
            if (m_axis_tvalid === 1'b1) got.push_back(out_beat());
            if (c < 2) begin
                b.data = 32'(32'hC0DE_0001 + c); b.keep = 4'hF; b.last = (c == 1);
                drive_beat(b);
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
        checks++;
        if (got.size() !== 2) begin
            errors++; $display("FAIL t5_count: got %0d words want 2", got.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                b.data = 32'(32'hC0DE_0001 + k); b.keep = 4'hF; b.last = (k == 1);
                if (got[k] !== b) begin errors++; $display("FAIL t5_word%0d: got %h want %h", k, got[k], b); end
            end
        end
    endtask

    // Random packets, gaps and back-pressure against a packet-queue model.
    // Normal packets are only started when they are guaranteed to fit, and
    // packets longer than the buffer are always expected to be dropped.
    task automatic test_random();
        beat_t exp[$];
        int drops_exp = 0;
        int drops_seen = 0;
        bit drv_done = 1'b0;
        int cyc = 0;
        do_reset();
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    beat_t pend[$];
                    int len;
                    bit big;
                    int w;
                    big = ($urandom_range(0, 5) == 0);
                    len = big ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 8));
                    w = 0;
                    while (!big && exp.size() + len > DEPTH && w < 4000) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 4000) begin
                        checks++; errors++; $display("FAIL rand_space_timeout: got %0d queued want <= %0d", exp.size(), DEPTH - len);
                    end
                    for (int i = 0; i < len; i++) begin
                        beat_t b;
                        while ($urandom_range(0, 3) == 0) begin
                            drive_idle();
                            @(negedge clk);
                        end
                        b.data = $urandom;
                        b.keep = 4'($urandom_range(1, 15));
                        b.last = (i == len - 1);
                        pend.push_back(b);
                        drive_beat(b);
                        @(negedge clk);
                    end
                    drive_idle();
                    if (big) drops_exp++;
                    else foreach (pend[k]) exp.push_back(pend[k]);
                end
                drv_done = 1'b1;
            end
            begin
                while (!(drv_done && exp.size() == 0) && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (drop_pulse === 1'b1) drops_seen++;
                    m_axis_tready = ($urandom_range(0, 2) != 0);
                    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                        checks++;
                        if (exp.size() == 0) begin
                            errors++; $display("FAIL rand_extra_word: got %h want nothing", out_beat());
                        end else begin
                            beat_t e;
                            e = exp.pop_front();
                            if (out_beat() !== e) begin errors++; $display("FAIL rand_word: got %h want %h", out_beat(), e); end
                        end
                    end
                end
            end
        join
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d words pending want 0", exp.size()); end
        m_axis_tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (drop_pulse === 1'b1) drops_seen++;
            checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rand_trailing_word: got %h want nothing", out_beat()); end
        end
        checks++; if (drops_seen !== drops_exp) begin errors++; $display("FAIL rand_drops: got %0d want %0d", drops_seen, drops_exp); end
        checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL rand_pkt_count: got %0d want 0", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_overflow();
        test_oversize();
        test_keep_toggle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
